// File: rtl/rooth_test_monitor_if.sv
// Bundle carrying the test-monitor control, writeback snoop and verdict signals.
//   master: drives start and the register-file writeback port (start, wb_en,
//           wb_addr, wb_data) and observes the verdict outputs.
//   slave : the monitor; consumes start/writeback and drives busy, done, pass,
//           tmo, fail_testnum, cycles, pass_cnt and fail_cnt.
interface rooth_test_monitor_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TCNT_W = 8
);
  logic              start;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic              tmo;
  logic [DATA_W-1:0] fail_testnum;
  logic [CNT_W-1:0]  cycles;
  logic [TCNT_W-1:0] pass_cnt;
  logic [TCNT_W-1:0] fail_cnt;

  modport master (
    output start, wb_en, wb_addr, wb_data,
    input  busy, done, pass, tmo, fail_testnum, cycles, pass_cnt, fail_cnt
  );

  modport slave (
    input  start, wb_en, wb_addr, wb_data,
    output busy, done, pass, tmo, fail_testnum, cycles, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/rooth_test_monitor.sv
// Self-check monitor for rooth regression runs. Snoops the register-file
// writeback port, keeps shadow copies of the done/result/testnum registers,
// and issues a one-cycle verdict after a settle window or a cycle timeout.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   mon  - slave side of rooth_test_monitor_if:
//          start           pulse, begin monitoring a new test (IDLE only)
//          wb_en/addr/data register-file writeback snoop
//          busy            high in RUN/SETTLE
//          done            one-cycle verdict strobe
//          pass, tmo       verdict flags, held until next start
//          fail_testnum    testnum shadow latched at verdict
//          cycles          RUN+SETTLE cycle count latched at verdict
//          pass_cnt/fail_cnt saturating tallies across tests
module rooth_test_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DONE_REG    = 26,
  parameter int unsigned RESULT_REG  = 27,
  parameter int unsigned TESTNUM_REG = 3,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TCNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rooth_test_monitor_if.slave  mon
);

  localparam int unsigned     SET_W     = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [4:0]      DONE_A    = 5'(DONE_REG);
  localparam logic [4:0]      RESULT_A  = 5'(RESULT_REG);
  localparam logic [4:0]      TESTNUM_A = 5'(TESTNUM_REG);
  localparam longint unsigned TO_LAST   = longint'(TIMEOUT) - 1;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, REPORT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   done_sh_q, done_sh_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   testnum_q, testnum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                pass_q, pass_d;
  logic                tmo_q, tmo_d;
  logic [DATA_W-1:0]   ftn_q, ftn_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [TCNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [TCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic                snoop_en;
  logic                done_wr;
  logic                verdict;
  logic                timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sh_q  <= '0;
      result_q   <= '0;
      testnum_q  <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ftn_q      <= '0;
      cycles_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      done_sh_q  <= done_sh_d;
      result_q   <= result_d;
      testnum_q  <= testnum_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
      ftn_q      <= ftn_d;
      cycles_q   <= cycles_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_sh_d  = done_sh_q;
    result_d   = result_q;
    testnum_d  = testnum_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    ftn_d      = ftn_q;
    cycles_d   = cycles_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    done_wr    = 1'b0;
    verdict    = 1'b0;
    timed_out  = 1'b0;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // x0 writes are never architectural, so they never touch a shadow.
    snoop_en = ((state_q == RUN) || (state_q == SETTLE)) && mon.wb_en && (mon.wb_addr != '0);
    if (snoop_en) begin
      if (mon.wb_addr == DONE_A) begin
        done_sh_d = mon.wb_data;
        done_wr   = 1'b1;
      end
      if (mon.wb_addr == RESULT_A)  result_d  = mon.wb_data;
      if (mon.wb_addr == TESTNUM_A) testnum_d = mon.wb_data;
    end

    case (state_q)
      IDLE: begin
        if (mon.start) begin
          state_d   = RUN;
          done_sh_d = '0;
          result_d  = '0;
          testnum_d = '0;
          cnt_d     = '0;
          pass_d    = 1'b0;
          tmo_d     = 1'b0;
          ftn_d     = '0;
          cycles_d  = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        // A qualifying done write takes priority over a coincident timeout.
        if (done_wr && (done_sh_d == DATA_W'(1))) begin
          state_d  = SETTLE;
          settle_d = SET_W'(SETTLE_CYC);
        end else if (64'(cnt_q) >= TO_LAST) begin
          state_d   = REPORT;
          verdict   = 1'b1;
          timed_out = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_inc;
        if (settle_q <= SET_W'(1)) begin
          state_d = REPORT;
          verdict = 1'b1;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Verdict registers load on the edge entering REPORT so they are valid
    // while done is high; result_d includes a write in the final SETTLE cycle.
    if (verdict) begin
      pass_d   = !timed_out && (result_d == DATA_W'(1));
      tmo_d    = timed_out;
      ftn_d    = testnum_d;
      cycles_d = cnt_d;
      if (pass_d) begin
        pass_cnt_d = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + 1'b1;
      end else begin
        fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + 1'b1;
      end
    end
  end

  assign mon.busy         = (state_q == RUN) || (state_q == SETTLE);
  assign mon.done         = (state_q == REPORT);
  assign mon.pass         = pass_q;
  assign mon.tmo          = tmo_q;
  assign mon.fail_testnum = ftn_q;
  assign mon.cycles       = cycles_q;
  assign mon.pass_cnt     = pass_cnt_q;
  assign mon.fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_rooth_test_monitor.sv
// Scoreboard bench for rooth_test_monitor. Each test is a plan of writeback
// activity indexed by RUN cycle; a reference model derives the verdict from
// the plan and pushes it, and a negedge monitor pops and compares on done.
module tb_rooth_test_monitor;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int TW   = 8;
  localparam int SC   = 1;
  localparam int TO   = 100;
  localparam int PLEN = 128;

  typedef struct {
    longint at;
    bit     pass;
    bit     tmo;
    logic [DW-1:0] tn;
    int     cycles;
    int     pcnt;
    int     fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  int m_pcnt = 0;
  int m_fcnt = 0;

  bit          p_en   [PLEN];
  logic [4:0]  p_addr [PLEN];
  logic [DW-1:0] p_data [PLEN];
  bit          p_start[PLEN];
  int          plen;

  rooth_test_monitor_if #(.DATA_W(DW), .CNT_W(CW), .TCNT_W(TW)) mon();

  rooth_test_monitor #(
    .DATA_W(DW), .SETTLE_CYC(SC), .TIMEOUT(TO), .CNT_W(CW), .TCNT_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mon.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_time", 64'(cyc), 64'(e.at));
        check("pass", 64'(mon.pass), 64'(e.pass));
        check("tmo", 64'(mon.tmo), 64'(e.tmo));
        check("fail_testnum", 64'(mon.fail_testnum), 64'(e.tn));
        check("cycles", 64'(mon.cycles), 64'(e.cycles));
        check("pass_cnt", 64'(mon.pass_cnt), 64'(e.pcnt));
        check("fail_cnt", 64'(mon.fail_cnt), 64'(e.fcnt));
        check("busy_at_done", 64'(mon.busy), 0);
      end
    end
  end

  task automatic clear_plan();
    for (int c = 0; c < PLEN; c++) begin
      p_en[c] = 1'b0; p_addr[c] = '0; p_data[c] = '0; p_start[c] = 1'b0;
    end
    plen = 0;
  endtask

  task automatic add_wr(input int c, input bit en, input int addr, input logic [DW-1:0] data);
    p_en[c] = en; p_addr[c] = 5'(addr); p_data[c] = data;
    if (c + 1 > plen) plen = c + 1;
  endtask

  function automatic bit wr_ok(input int c);
    return (c < plen) && p_en[c] && (p_addr[c] != 5'd0);
  endfunction

  // Reference: first done==1 write within the timeout window ends the test;
  // result/testnum are the last writes up to the end of the settle window.
  function automatic exp_t model();
    exp_t e;
    int k = -1;
    int last;
    logic [DW-1:0] res = '0;
    for (int c = 0; c < TO; c++) begin
      if (wr_ok(c) && p_addr[c] == 5'd26 && p_data[c] == 1) begin
        k = c;
        break;
      end
    end
    if (k >= 0) begin
      last = k + SC; e.cycles = k + 1 + SC; e.tmo = 1'b0;
    end else begin
      last = TO - 1; e.cycles = TO; e.tmo = 1'b1;
    end
    e.tn = '0;
    for (int c = 0; c <= last; c++) begin
      if (wr_ok(c) && p_addr[c] == 5'd27) res = p_data[c];
      if (wr_ok(c) && p_addr[c] == 5'd3)  e.tn = p_data[c];
    end
    e.pass = !e.tmo && (res == 1);
    if (e.pass) m_pcnt = (m_pcnt < 255) ? m_pcnt + 1 : 255;
    else        m_fcnt = (m_fcnt < 255) ? m_fcnt + 1 : 255;
    e.pcnt = m_pcnt;
    e.fcnt = m_fcnt;
    return e;
  endfunction

  task automatic idle_bus();
    mon.wb_en = 1'b0; mon.wb_addr = '0; mon.wb_data = '0;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic do_test();
    exp_t e;
    bit seen = 1'b0;
    e = model();
    idle_bus();
    mon.start = 1'b1;
    e.at = cyc + 1 + e.cycles;
    sb.push_back(e);
    @(posedge clk); #1;
    check("busy_run0", 64'(mon.busy), 1);
    for (int c = 0; c < 250; c++) begin
      if (c < plen) begin
        mon.start = p_start[c]; mon.wb_en = p_en[c];
        mon.wb_addr = p_addr[c]; mon.wb_data = p_data[c];
      end else begin
        mon.start = 1'b0; idle_bus();
      end
      seen = mon.done;
      @(posedge clk); #1;
      if (seen) break;
    end
    mon.start = 1'b0;
    idle_bus();
    if (!seen) check("done_wait", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(mon.busy), 0);
    check({tag, "_done"}, 64'(mon.done), 0);
    check({tag, "_pass"}, 64'(mon.pass), 0);
    check({tag, "_tmo"}, 64'(mon.tmo), 0);
    check({tag, "_ftn"}, 64'(mon.fail_testnum), 0);
    check({tag, "_cycles"}, 64'(mon.cycles), 0);
    check({tag, "_pcnt"}, 64'(mon.pass_cnt), 0);
    check({tag, "_fcnt"}, 64'(mon.fail_cnt), 0);
  endtask

  initial begin
    mon.start = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // pass, done at RUN cycle 10
    clear_plan(); add_wr(5, 1, 27, 1); add_wr(10, 1, 26, 1);
    do_test();
    // fail with testnum
    clear_plan(); add_wr(0, 1, 3, 5); add_wr(1, 1, 27, 0); add_wr(2, 1, 26, 1);
    do_test();
    // result arriving in the SETTLE cycle counts
    clear_plan(); add_wr(0, 1, 26, 1); add_wr(1, 1, 27, 1);
    do_test();
    // result arriving in REPORT is too late
    clear_plan(); add_wr(0, 1, 26, 1); add_wr(2, 1, 27, 1);
    do_test();
    // filtering: non-1 done value, x0 write, disabled write
    clear_plan(); add_wr(0, 1, 26, 2); add_wr(1, 1, 0, 1); add_wr(2, 0, 26, 1);
    add_wr(3, 1, 27, 1); add_wr(4, 1, 26, 1);
    do_test();
    // timeout with no done write
    clear_plan(); add_wr(7, 1, 3, 32'h77);
    do_test();
    // done write coincident with the last timeout cycle wins
    clear_plan(); add_wr(50, 1, 27, 1); add_wr(99, 1, 26, 1);
    do_test();
    // start pulses while busy are ignored
    clear_plan(); p_start[3] = 1'b1; p_start[7] = 1'b1; add_wr(9, 1, 26, 1);
    do_test();

    // randomized plans
    for (int t = 0; t < 40; t++) begin
      clear_plan();
      plen = int'($urandom_range(1, 40));
      for (int c = 0; c < plen; c++) begin
        int sel;
        p_en[c] = 1'($urandom % 2);
        sel = int'($urandom % 6);
        p_addr[c] = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd3 : (sel == 2 || sel == 5) ? 5'd26 :
                    (sel == 3) ? 5'd27 : 5'($urandom);
        p_data[c] = ($urandom % 3 == 0) ? DW'($urandom) : DW'($urandom % 3);
        p_start[c] = ($urandom % 8 == 0);
      end
      do_test();
    end

    // reset mid-RUN
    clear_plan(); add_wr(40, 1, 26, 1);
    mon.start = 1'b1;
    @(posedge clk); #1;
    mon.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_rst", 64'(mon.busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    sb.delete();
    m_pcnt = 0;
    m_fcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("postrst");

    // saturating pass tally
    for (int t = 0; t < 300; t++) begin
      clear_plan(); add_wr(0, 1, 27, 1); add_wr(1, 1, 26, 1);
      do_test();
    end
    check("pass_cnt_sat", 64'(mon.pass_cnt), 255);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
